// File: rtl/mdu_control_if.sv
// Pipeline-to-MDU bus for the EX stage: instruction/operand inputs, stall and HI/LO outputs.
// o_div_by_zero is present only when MDU_DIVZERO_FLAG_EN is defined.
interface mdu_control_if #(
    parameter int NB_DATA   = 32,
    parameter int NB_FCODE  = 6,
    parameter int NB_OPCODE = 6
);
    logic                 i_valid;
    logic                 i_flush;
    logic [NB_OPCODE-1:0] i_opcode;
    logic [NB_FCODE-1:0]  i_funct_code;
    logic [NB_DATA-1:0]   i_rs;
    logic [NB_DATA-1:0]   i_rt;
    logic                 o_stall;
    logic                 o_busy;
    logic [NB_DATA-1:0]   o_result;
    logic                 o_result_valid;
    logic [NB_DATA-1:0]   o_hi;
    logic [NB_DATA-1:0]   o_lo;
`ifdef MDU_DIVZERO_FLAG_EN
    logic                 o_div_by_zero;

    modport master (
        output i_valid, i_flush, i_opcode, i_funct_code, i_rs, i_rt,
        input  o_stall, o_busy, o_result, o_result_valid, o_hi, o_lo, o_div_by_zero
    );
    modport slave (
        input  i_valid, i_flush, i_opcode, i_funct_code, i_rs, i_rt,
        output o_stall, o_busy, o_result, o_result_valid, o_hi, o_lo, o_div_by_zero
    );
`else
    modport master (
        output i_valid, i_flush, i_opcode, i_funct_code, i_rs, i_rt,
        input  o_stall, o_busy, o_result, o_result_valid, o_hi, o_lo
    );
    modport slave (
        input  i_valid, i_flush, i_opcode, i_funct_code, i_rs, i_rt,
        output o_stall, o_busy, o_result, o_result_valid, o_hi, o_lo
    );
`endif
endinterface

// File: rtl/mdu_control.sv
// EX-stage multiply/divide unit: iterative shift-add MULT and restoring DIV with HI/LO and stall.
// Optional MDU_DIVZERO_FLAG_EN adds the sticky o_div_by_zero output.
module mdu_control #(
    parameter int NB_DATA   = 32,
    parameter int NB_FCODE  = 6,
    parameter int NB_OPCODE = 6
) (
    input  logic         i_clk,
    input  logic         i_reset,
    mdu_control_if.slave mdu
);
    localparam int CNT_W = $clog2(NB_DATA);
    localparam logic [NB_OPCODE-1:0] OP_RTYPE = '0;
    localparam logic [NB_FCODE-1:0]  F_MFHI   = NB_FCODE'(8'h10);
    localparam logic [NB_FCODE-1:0]  F_MTHI   = NB_FCODE'(8'h11);
    localparam logic [NB_FCODE-1:0]  F_MFLO   = NB_FCODE'(8'h12);
    localparam logic [NB_FCODE-1:0]  F_MTLO   = NB_FCODE'(8'h13);
    localparam logic [NB_FCODE-1:0]  F_MULT   = NB_FCODE'(8'h18);
    localparam logic [NB_FCODE-1:0]  F_MULTU  = NB_FCODE'(8'h19);
    localparam logic [NB_FCODE-1:0]  F_DIV    = NB_FCODE'(8'h1A);
    localparam logic [NB_FCODE-1:0]  F_DIVU   = NB_FCODE'(8'h1B);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [NB_DATA-1:0] r_hi;
    logic [NB_DATA-1:0] r_lo;
    logic [NB_DATA-1:0] r_acc_hi;
    logic [NB_DATA-1:0] r_acc_lo;
    logic [NB_DATA-1:0] r_operand;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_div;

    logic               w_rtype, w_mfhi, w_mflo, w_mthi, w_mtlo, w_muldiv, w_mdu_op;
    logic               w_signed, w_is_div, w_idle, w_take;
    logic [NB_DATA-1:0] w_abs_rs, w_abs_rt;

    assign w_rtype  = (mdu.i_opcode == OP_RTYPE);
    assign w_mfhi   = w_rtype & (mdu.i_funct_code == F_MFHI);
    assign w_mflo   = w_rtype & (mdu.i_funct_code == F_MFLO);
    assign w_mthi   = w_rtype & (mdu.i_funct_code == F_MTHI);
    assign w_mtlo   = w_rtype & (mdu.i_funct_code == F_MTLO);
    assign w_muldiv = w_rtype & (mdu.i_funct_code inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign w_mdu_op = w_mfhi | w_mflo | w_mthi | w_mtlo | w_muldiv;
    assign w_signed = (mdu.i_funct_code == F_MULT) | (mdu.i_funct_code == F_DIV);
    assign w_is_div = (mdu.i_funct_code == F_DIV) | (mdu.i_funct_code == F_DIVU);
    assign w_idle   = (r_state == S_IDLE);
    assign w_take   = w_idle & mdu.i_valid & ~mdu.i_flush;
    assign w_abs_rs = (w_signed & mdu.i_rs[NB_DATA-1]) ? -mdu.i_rs : mdu.i_rs;
    assign w_abs_rt = (w_signed & mdu.i_rt[NB_DATA-1]) ? -mdu.i_rt : mdu.i_rt;

    // Multiply: acc_lo holds the multiplier and shifts right as the product fills in from the top.
    logic [NB_DATA:0]   w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_operand} : '0);

    // Divide: acc_lo holds the dividend shifting out and the quotient shifting in; acc_hi is the remainder.
    logic [NB_DATA:0]   w_rem_sh, w_rem_sub;
    logic               w_q_bit;
    assign w_rem_sh  = {r_acc_hi, r_acc_lo[NB_DATA-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_operand};
    assign w_q_bit   = ~w_rem_sub[NB_DATA];

    logic                   w_neg_res, w_div_zero;
    logic [2*NB_DATA-1:0]   w_prod;
    logic [NB_DATA-1:0]     w_quot, w_rem;
    assign w_neg_res  = r_sign_a ^ r_sign_b;
    assign w_prod     = w_neg_res ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    assign w_div_zero = r_div & (r_operand == '0);
    assign w_quot     = w_div_zero ? '1 : (w_neg_res ? -r_acc_lo : r_acc_lo);
    // Negating |rs| restores the original rs, which also yields HI=rs on divide by zero.
    assign w_rem      = r_sign_a ? -r_acc_hi : r_acc_hi;

`ifdef MDU_DIVZERO_FLAG_EN
    logic r_div_by_zero;
    assign mdu.o_div_by_zero = r_div_by_zero;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_operand <= '0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_div     <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
            r_div_by_zero <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take & w_muldiv) begin
                        r_state   <= S_RUN;
                        r_count   <= '0;
                        r_div     <= w_is_div;
                        r_sign_a  <= w_signed & mdu.i_rs[NB_DATA-1];
                        r_sign_b  <= w_signed & mdu.i_rt[NB_DATA-1];
                        r_acc_hi  <= '0;
                        r_operand <= w_is_div ? w_abs_rt : w_abs_rs;
                        r_acc_lo  <= w_is_div ? w_abs_rs : w_abs_rt;
                    end
                    if (w_take & w_mthi) r_hi <= mdu.i_rs;
                    if (w_take & w_mtlo) r_lo <= mdu.i_rs;
`ifdef MDU_DIVZERO_FLAG_EN
                    if (w_take & (w_mthi | w_mtlo)) r_div_by_zero <= 1'b0;
`endif
                end
                S_RUN: begin
                    if (mdu.i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_div) begin
                            r_acc_hi <= w_q_bit ? w_rem_sub[NB_DATA-1:0] : w_rem_sh[NB_DATA-1:0];
                            r_acc_lo <= {r_acc_lo[NB_DATA-2:0], w_q_bit};
                        end else begin
                            r_acc_hi <= w_mul_sum[NB_DATA:1];
                            r_acc_lo <= {w_mul_sum[0], r_acc_lo[NB_DATA-1:1]};
                        end
                        r_count <= r_count + 1'b1;
                        if (r_count == CNT_W'(NB_DATA-1)) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!mdu.i_flush) begin
                        if (r_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod[2*NB_DATA-1:NB_DATA];
                            r_lo <= w_prod[NB_DATA-1:0];
                        end
`ifdef MDU_DIVZERO_FLAG_EN
                        r_div_by_zero <= w_div_zero;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mdu.o_busy         = ~w_idle;
    assign mdu.o_stall        = ~w_idle & mdu.i_valid & w_mdu_op;
    assign mdu.o_hi           = r_hi;
    assign mdu.o_lo           = r_lo;
    assign mdu.o_result_valid = w_idle & mdu.i_valid & (w_mfhi | w_mflo);
    always_comb begin
        mdu.o_result = '0;
        if (w_idle & mdu.i_valid & w_mfhi)      mdu.o_result = r_hi;
        else if (w_idle & mdu.i_valid & w_mflo) mdu.o_result = r_lo;
    end
endmodule

// File: tb/tb_mdu_control.sv
// Self-checking bench for mdu_control: directed test-plan steps plus randomized ops
// checked against an arithmetic HI/LO reference model.
module tb_mdu_control;
    localparam int N = 32;
    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B, ADD = 6'h20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_control_if #(.NB_DATA(N), .NB_FCODE(6), .NB_OPCODE(6)) bus ();
    mdu_control #(.NB_DATA(N), .NB_FCODE(6), .NB_OPCODE(6)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .mdu     (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: HI/LO from plain 64-bit arithmetic.
    task automatic model(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        logic [63:0] p, q, r;
        longint      sa, sb;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        case (f)
            MULT:  begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0; end
            MULTU: begin p = {32'b0, rs} * {32'b0, rt}; m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0; end
            DIV, DIVU: begin
                if (rt == 0) begin
                    m_hi = rs; m_lo = '1; m_dz = 1'b1;
                end else begin
                    if (f == DIV) begin q = 64'(sa / sb); r = 64'(sa % sb); end
                    else begin q = {32'b0, rs} / {32'b0, rt}; r = {32'b0, rs} % {32'b0, rt}; end
                    m_lo = q[31:0]; m_hi = r[31:0]; m_dz = 1'b0;
                end
            end
            MTHI:  begin m_hi = rs; m_dz = 1'b0; end
            MTLO:  begin m_lo = rs; m_dz = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        bus.i_valid      = 1'b1;
        bus.i_opcode     = '0;
        bus.i_funct_code = f;
        bus.i_rs         = rs;
        bus.i_rt         = rt;
    endtask

    task automatic check_regs(input string tag);
        check({tag, " hi"}, bus.o_hi, m_hi);
        check({tag, " lo"}, bus.o_lo, m_lo);
`ifdef MDU_DIVZERO_FLAG_EN
        check({tag, " dz"}, bus.o_div_by_zero, m_dz);
`endif
    endtask

    // All op tasks start and end just after a falling edge.
    task automatic run_muldiv(input string tag, input logic [5:0] f,
                              input logic [31:0] rs, input logic [31:0] rt);
        int cyc = 0;
        drive(f, rs, rt);
        #1 check({tag, " stall"}, bus.o_stall, 0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        while (bus.o_busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        model(f, rs, rt);
        check({tag, " busy cycles"}, cyc, N + 1);
        check_regs(tag);
    endtask

    task automatic run_mf(input string tag, input logic [5:0] f);
        drive(f, $urandom, $urandom);
        #1;
        check({tag, " rvalid"}, bus.o_result_valid, 1);
        check({tag, " result"}, bus.o_result, (f == MFHI) ? m_hi : m_lo);
        check({tag, " stall"}, bus.o_stall, 0);
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic run_mt(input string tag, input logic [5:0] f, input logic [31:0] rs);
        drive(f, rs, $urandom);
        @(negedge clk);
        bus.i_valid = 1'b0;
        model(f, rs, '0);
        check_regs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, stalls;
        logic [5:0]  ops [8];
        logic [5:0]  f;
        logic [31:0] a, b;
        ops = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO};

        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_opcode = '0;
        bus.i_funct_code = '0; bus.i_rs = '0; bus.i_rt = '0;
        #12;
        check("reset busy", bus.o_busy, 0);
        check("reset rvalid", bus.o_result_valid, 0);
        check("reset result", bus.o_result, 0);
        check_regs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_muldiv("mult 7*-3", MULT, 32'd7, 32'hFFFF_FFFD);
        check("mult 7*-3 const", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_mf("mflo after mult", MFLO);
        run_muldiv("multu max", MULTU, '1, '1);
        check("multu max const", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFE_0000_0001);
        run_muldiv("mult -1*-1", MULT, '1, '1);
        run_muldiv("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2);
        check("div -7/2 const", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_muldiv("div overflow", DIV, 32'h8000_0000, '1);
        check("div overflow const", {bus.o_hi, bus.o_lo}, 64'h0000_0000_8000_0000);
        run_muldiv("divu by 0", DIVU, 32'd100, 32'd0);
        run_mf("mfhi after div0", MFHI);
        run_muldiv("div -9 by 0", DIV, 32'hFFFF_FFF7, 32'd0);
        run_muldiv("mult clears dz", MULT, 32'd12345, 32'hFFFF_0001);

        // MULT with a stalled MFHI behind it; one cycle swapped for a non-MDU ADD.
        drive(MULT, 32'h1234_5678, 32'h9ABC_DEF1);
        @(negedge clk);
        drive(MFHI, '0, '0);
        cyc = 0; stalls = 0;
        while (bus.o_busy === 1'b1 && cyc < 100) begin
            #1;
            if (bus.o_stall === 1'b1 && bus.o_result_valid === 1'b0) stalls++;
            if (cyc == 5) begin
                bus.i_funct_code = ADD;
                #1 check("add no stall", bus.o_stall, 0);
                bus.i_funct_code = MFHI;
            end
            cyc++;
            @(negedge clk);
        end
        model(MULT, 32'h1234_5678, 32'h9ABC_DEF1);
        #1;
        check("mfhi stalled cycles", stalls, N + 1);
        check("mfhi released stall", bus.o_stall, 0);
        check("mfhi released rvalid", bus.o_result_valid, 1);
        check("mfhi released result", bus.o_result, m_hi);
        @(negedge clk);
        bus.i_valid = 1'b0;

        // Flush mid-DIV leaves HI/LO alone.
        drive(DIV, 32'd1000, 32'd7);
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        check("flush busy", bus.o_busy, 0);
        repeat (40) @(negedge clk);
        check_regs("after flush");

        // Flush in IDLE blocks MTHI and MULT acceptance.
        bus.i_flush = 1'b1;
        drive(MTHI, 32'hDEAD_BEEF, '0);
        @(negedge clk);
        drive(MULT, 32'd3, 32'd5);
        @(negedge clk);
        bus.i_valid = 1'b0; bus.i_flush = 1'b0;
        check("idle flush busy", bus.o_busy, 0);
        check_regs("idle flush");

        run_mt("mtlo", MTLO, 32'hCAFE_F00D);
        run_muldiv("divu 0 again", DIVU, 32'd5, 32'd0);
        run_mt("mthi clears dz", MTHI, 32'h0BAD_CAFE);

        for (int i = 0; i < 40; i++) begin
            f = ops[$urandom_range(0, 7)];
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = '1; end
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            case (f)
                MFHI, MFLO:  run_mf("rand mf", f);
                MTHI, MTLO:  run_mt("rand mt", f, a);
                default:     run_muldiv("rand muldiv", f, a, b);
            endcase
        end

        // Asynchronous reset mid-MULT.
        drive(MULT, 32'h0001_0001, 32'h7777_7777);
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        check("reset mid busy", bus.o_busy, 0);
        check_regs("reset mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_muldiv("post reset", MULTU, 32'd6, 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_control.md
Name: mdu_control

Overview:
- Execute-stage multiply/divide unit with control, a successor to the combinational ALU decode. It decodes R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO funct codes.
- Runs multi-cycle iterative shift-add multiply and restoring divide, holds the architectural HI/LO registers, and stalls the pipeline while busy.
- Sits beside the ALU in EX. Non-MDU instructions never stall.

Parameters:
NB_DATA, 32, operand/HI/LO width (even, >=4)
NB_FCODE, 6, funct code width
NB_OPCODE, 6, opcode width

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  instruction in EX is live (not bubble)
i_flush  in  1  abort in-flight MULT/DIV
i_opcode  in  NB_OPCODE  instruction opcode
i_funct_code  in  NB_FCODE  R-type funct
i_rs  in  NB_DATA  rs operand (multiplicand/dividend, MTHI/MTLO source)
i_rt  in  NB_DATA  rt operand (multiplier/divisor)
o_stall  out  1  hold IF/ID/EX this cycle
o_busy  out  1  iteration in progress
o_result  out  NB_DATA  MFHI/MFLO read data
o_result_valid  out  1  o_result valid this cycle
o_hi  out  NB_DATA  HI register
o_lo  out  NB_DATA  LO register

Behaviour:
- Decode is active only when opcode==0 (R-type). Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
  - Any other funct or opcode is not an MDU op.
- Reset (async): state IDLE, HI=LO=0, counter=0, all datapath registers 0, all outputs 0.
- States: IDLE, RUN, FIX.
- IDLE:
  - i_valid & MULT*/DIV*: latch operands, sign flags and op type. Signed ops latch absolute values; unsigned ops latch raw values. Go to RUN with counter=0.
  - i_valid & MTHI: HI<=i_rs at the edge. i_valid & MTLO: LO<=i_rs at the edge.
  - i_valid & MFHI/MFLO: o_result=HI/LO combinationally in the same cycle, o_result_valid=1. No stall.
- RUN:
  - One bit per cycle: multiply is shift-add into a 2*NB_DATA product; divide is restoring divide, yielding quotient and remainder.
  - Counter increments each cycle. At counter==NB_DATA-1, go to FIX.
- FIX:
  - Signed MULT: negate the product if sign_a^sign_b.
  - Signed DIV: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Write HI/LO at the FIX edge: MULT writes HI=product[2N-1:N], LO=product[N-1:0]. DIV writes LO=quotient, HI=remainder. Then go to IDLE.
- Latency: for an accept edge E0, HI/LO update at edge E0+NB_DATA+1 (33 for N=32). o_busy=1 for those NB_DATA+1 cycles.
- o_stall is combinational: (state!=IDLE) & i_valid & (decoded op is any MDU op). A stalled MDU instruction is re-presented by the pipeline and accepted/serviced once the unit is IDLE.
- Divide by zero: uses the same latency, no sign fix. Result is HI=original i_rs, LO=all ones.
- Signed overflow (most-negative / -1): LO=most-negative value, HI=0. This falls out of N-bit abs/negate arithmetic.
- i_flush in RUN/FIX: go to IDLE next edge, HI/LO unchanged, o_busy deasserts. i_flush in IDLE also blocks acceptance and MTHI/MTLO that cycle.
- Reset mid-operation: immediate abort, HI/LO cleared.
- MTHI/MTLO/MFHI/MFLO while busy: stalled, never corrupt the in-flight result.

Optional Feature:
- Macro MDU_DIVZERO_FLAG_EN.
- Defined: extra output o_div_by_zero (1 bit), reset 0. Set at the FIX edge of a DIV/DIVU with divisor 0. Cleared at the FIX edge of any other MULT/DIV, or by MTHI/MTLO.
- Undefined: port absent; divide-by-zero results unchanged.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) -> o_busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB; MFLO next cycle returns 0xFFFFFFEB with o_result_valid=1.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MULT with the same operands -> HI=0, LO=1.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=100, rt=0 -> HI=100, LO=0xFFFFFFFF; with MDU_DIVZERO_FLAG_EN, o_div_by_zero=1 until the next MULT clears it.
- MULT issued, then MFHI presented on cycle 2 -> o_stall=1 through cycle 33. An ADD (opcode 0, funct 0x20) presented alongside -> o_stall=0. MFHI then returns the new HI.
- i_flush asserted at cycle 10 of DIV -> IDLE next edge, HI/LO keep prior values. i_reset asserted mid-MULT -> HI=LO=0, o_busy=0 immediately.
